// File: rtl/core_pkg.sv
// core_pkg: opcodes, ALU codes, reg_src encodings and the decoded micro-op shared by the decode stage
package core_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;
  localparam logic [1:0] RS_IMM  = 2'b11;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  reg_src;
    logic        reg_wen;
    logic        mem_wen;
    logic        mem_ren;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        auipc;
    logic        alu_b_reg;
    logic        muldiv;
    logic        illegal;
    logic        ebreak;
  } uop_t;
  // alt selects SUB on funct3 000 and SRA on funct3 101
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_buffered_if.sv
// id_stage_buffered_if: fetch-side and execute-side handshakes of the decode stage
interface id_stage_buffered_if #(parameter int PC_W = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3;
  logic [31:0]     out_imm;
  logic [4:0]      out_alu_op;
  logic [1:0]      out_reg_src;
  logic            out_reg_wen, out_mem_wen, out_mem_ren, out_branch, out_jump, out_jalr, out_auipc, out_alu_b_reg;
  logic            out_muldiv, out_illegal, out_ebreak;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_alu_op, out_reg_src,
           out_reg_wen, out_mem_wen, out_mem_ren, out_branch, out_jump, out_jalr, out_auipc, out_alu_b_reg,
           out_muldiv, out_illegal, out_ebreak
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_alu_op, out_reg_src,
           out_reg_wen, out_mem_wen, out_mem_ren, out_branch, out_jump, out_jalr, out_auipc, out_alu_b_reg,
           out_muldiv, out_illegal, out_ebreak
  );
endinterface

// File: rtl/id_decode_comb.sv
// id_decode_comb: combinational RV32I(+M) instruction to micro-op decode
module id_decode_comb import core_pkg::*; #(
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0] instr,
  output uop_t        uop
);
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    uop        = '0;
    uop.rs1    = instr[19:15];
    uop.rs2    = instr[24:20];
    uop.rd     = instr[11:7];
    uop.funct3 = f3;
    uop.ebreak = instr == INSTR_EBREAK;
    case (opc)
      OP_LUI:    begin uop.imm = imm_u; uop.reg_src = RS_IMM; uop.reg_wen = 1'b1; end
      OP_AUIPC:  begin uop.imm = imm_u; uop.auipc = 1'b1; uop.reg_wen = 1'b1; end
      OP_JAL:    begin uop.imm = imm_j; uop.jump = 1'b1; uop.reg_src = RS_PC4; uop.reg_wen = 1'b1; end
      OP_JALR:   begin uop.imm = imm_i; uop.jump = 1'b1; uop.jalr = 1'b1; uop.reg_src = RS_PC4; uop.reg_wen = 1'b1; end
      OP_BRANCH: begin
        uop.imm       = imm_b;
        uop.branch    = 1'b1;
        uop.alu_b_reg = 1'b1;
        uop.alu_op    = f3[1] ? ALU_SLTU : ALU_SLT;
        uop.illegal   = f3[2:1] == 2'b01;
      end
      OP_LOAD:   begin
        uop.imm     = imm_i;
        uop.mem_ren = 1'b1;
        uop.reg_src = RS_LOAD;
        uop.reg_wen = 1'b1;
        uop.illegal = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE:  begin uop.imm = imm_s; uop.mem_wen = 1'b1; uop.illegal = f3 >= 3'd3; end
      OP_IMM:    begin
        uop.imm     = imm_i;
        uop.reg_wen = 1'b1;
        uop.alu_op  = alu_base(f3, f3 == 3'd5 && instr[30]);
        uop.illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_OP:     begin
        uop.alu_b_reg = 1'b1;
        uop.reg_wen   = 1'b1;
        uop.muldiv    = f7 == 7'h01;
        uop.alu_op    = f7 == 7'h01 ? (ALU_MUL | {2'b00, f3}) : alu_base(f3, instr[30]);
        uop.illegal   = f7 == 7'h01 ? !HAS_M : !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_SYSTEM: uop.illegal = !uop.ebreak;
      default:   uop.illegal = 1'b1;
    endcase
    if (uop.illegal) begin
      uop.reg_wen = 1'b0;
      uop.mem_wen = 1'b0;
      uop.mem_ren = 1'b0;
      uop.branch  = 1'b0;
      uop.jump    = 1'b0;
      uop.muldiv  = 1'b0;
    end
    if (uop.rd == 5'd0) uop.reg_wen = 1'b0;
  end
endmodule

// File: rtl/id_stage_buffered.sv
// id_stage_buffered: instruction queue feeding a registered decode output with valid/ready on both sides
module id_stage_buffered import core_pkg::*; #(
  parameter int DEPTH = 2,
  parameter bit HAS_M = 1'b1,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  id_stage_buffered_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  uop_t            uop_q, uop_d, dec_uop;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            push, pop;
  id_decode_comb #(.HAS_M(HAS_M)) u_dec (.instr(mem_q[rd_ptr_q].instr), .uop(dec_uop));
  // in_ready depends only on the occupancy register, never on out_ready
  assign bus.in_ready = cnt_q != (AW+1)'(DEPTH);
  always_comb begin
    push        = bus.in_valid && bus.in_ready && !bus.flush;
    pop         = cnt_q != '0 && (!out_valid_q || bus.out_ready);
    mem_d       = mem_q;
    if (push) mem_d[wr_ptr_q] = '{instr: bus.in_instr, pc: bus.in_pc};
    wr_ptr_d    = bus.flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d    = bus.flush ? '0 : rd_ptr_q + AW'(pop);
    cnt_d       = bus.flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    out_valid_d = bus.flush ? 1'b0 : pop ? 1'b1 : out_valid_q && !bus.out_ready;
    uop_d       = bus.flush ? '0 : pop ? dec_uop : uop_q;
    pc_d        = bus.flush ? '0 : pop ? mem_q[rd_ptr_q].pc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      uop_q       <= '0;
      pc_q        <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      uop_q       <= uop_d;
      pc_q        <= pc_d;
    end
  end
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_rs1       = uop_q.rs1;
  assign bus.out_rs2       = uop_q.rs2;
  assign bus.out_rd        = uop_q.rd;
  assign bus.out_funct3    = uop_q.funct3;
  assign bus.out_imm       = uop_q.imm;
  assign bus.out_alu_op    = uop_q.alu_op;
  assign bus.out_reg_src   = uop_q.reg_src;
  assign bus.out_reg_wen   = uop_q.reg_wen;
  assign bus.out_mem_wen   = uop_q.mem_wen;
  assign bus.out_mem_ren   = uop_q.mem_ren;
  assign bus.out_branch    = uop_q.branch;
  assign bus.out_jump      = uop_q.jump;
  assign bus.out_jalr      = uop_q.jalr;
  assign bus.out_auipc     = uop_q.auipc;
  assign bus.out_alu_b_reg = uop_q.alu_b_reg;
  assign bus.out_muldiv    = uop_q.muldiv;
  assign bus.out_illegal   = uop_q.illegal;
  assign bus.out_ebreak    = uop_q.ebreak;
endmodule
